beep_generator: RTL and testbench

Downstream stage of the metronome tick logic. It converts a one-cycle beat strobe into an audible square-wave burst on the speaker pin, with a higher pitch for accented beats. The metronome core drives beat/accent; this block owns the speaker output and the beep timing.

---
 rtl/metronome_pkg.sv | 22 ++
 rtl/tone_divider.sv | 64 ++++++
 rtl/beep_generator.sv | 108 ++++++++++
 tb/tb_beep_generator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : metronome_pkg
//  Brief   : Shared types, defaults and helpers for the metronome blocks.
//  Revision: 1.0  initial release
// ============================================================================
package metronome_pkg;

    localparam int unsigned FREQ_DEFAULT = 24_000_000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_TONE = 1'b1
    } beep_state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_divider.sv
`default_nettype none
// ============================================================================
//  Module  : tone_divider
//  Brief   : Half-period counter and toggle flop producing the burst square wave.
//  Revision: 1.0  initial release
// ============================================================================
module tone_divider #(
    parameter int unsigned HALF_N     = 10,
    parameter int unsigned HALF_A     = 5,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic sel_acc,
    input  logic restart,
    input  logic run,
    output logic wave
);
    import metronome_pkg::*;

    localparam int unsigned HMAX = (HALF_N > HALF_A) ? HALF_N : HALF_A;
    localparam int unsigned CW   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam logic [CW-1:0] TERM_N = CW'(HALF_N - 1);
    localparam logic [CW-1:0] TERM_A = CW'(HALF_A - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wave_q, wave_d;
    logic [CW-1:0] term;

    // The wave starts every burst in the driven (non-idle) half.
    always_comb begin
        term   = sel_acc ? TERM_A : TERM_N;
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart) begin
            cnt_d  = '0;
            wave_d = ~IDLE_LEVEL;
        end else if (run) begin
            if (cnt_q == term) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = '0;
            wave_d = IDLE_LEVEL;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= IDLE_LEVEL;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule
`default_nettype wire

// File: rtl/beep_generator.sv
`default_nettype none
// ============================================================================
//  Module  : beep_generator
//  Brief   : Turns a beat strobe into a fixed-length square-wave burst.
//  Revision: 1.0  initial release
// ============================================================================
module beep_generator
    import metronome_pkg::*;
#(
    parameter int unsigned FREQ       = FREQ_DEFAULT,
    parameter int unsigned TONE_HZ    = 1000,
    parameter int unsigned ACCENT_HZ  = 2000,
    parameter int unsigned BEEP_MS    = 60,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic beat,
    input  logic accent,
    input  logic enable,
    output logic speaker,
    output logic busy
);

    localparam int unsigned HALF_N   = FREQ / (2 * TONE_HZ);
    localparam int unsigned HALF_A   = FREQ / (2 * ACCENT_HZ);
    localparam int unsigned BEEP_CYC = ms_to_cycles(FREQ, BEEP_MS);
    localparam int unsigned HMAX     = (HALF_N > HALF_A) ? HALF_N : HALF_A;
    localparam int unsigned DUR_W    = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(BEEP_CYC - 1);

    if (HALF_A < 1 || HALF_N < 1 || BEEP_CYC < 2 * HMAX) begin : g_param_check
        $error("beep_generator: tone half-periods must be >=1 and burst >= one full period");
    end

    beep_state_e      state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             restart, run, start;

    assign start = beat & enable;

    // A new beat always wins, even on the last cycle of a burst.
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        restart = 1'b0;
        run     = 1'b0;
        if (start) begin
            state_d = ST_TONE;
            dur_d   = '0;
            acc_d   = accent;
            busy_d  = 1'b1;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_TONE: begin
                    if (!enable || dur_q == DUR_LAST) begin
                        state_d = ST_IDLE;
                        dur_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                        run   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
        end
    end

    tone_divider #(
        .HALF_N     (HALF_N),
        .HALF_A     (HALF_A),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_tone_divider (
        .sys_clk (sys_clk),
        .rst     (rst),
        .sel_acc (acc_q),
        .restart (restart),
        .run     (run),
        .wave    (speaker)
    );

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_beep_generator.sv
`default_nettype none
// ============================================================================
//  Module  : tb_beep_generator
//  Brief   : Self-checking bench for beep_generator against a timing model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_beep_generator;

    localparam int unsigned FREQ      = 10_000;
    localparam int unsigned TONE_HZ   = 500;
    localparam int unsigned ACCENT_HZ = 1000;
    localparam int unsigned BEEP_MS   = 2;
    localparam logic        IDLE      = 1'b1;
    localparam int          HN        = FREQ / (2 * TONE_HZ);
    localparam int          HA        = FREQ / (2 * ACCENT_HZ);
    localparam int          BC        = (FREQ / 1000) * BEEP_MS;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic beat    = 1'b0;
    logic accent  = 1'b0;
    logic enable  = 1'b1;
    logic speaker;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a burst is "active" with an elapsed-cycle count since its start.
    bit m_active  = 1'b0;
    int m_elapsed = 0;
    bit m_acc     = 1'b0;

    beep_generator #(
        .FREQ       (FREQ),
        .TONE_HZ    (TONE_HZ),
        .ACCENT_HZ  (ACCENT_HZ),
        .BEEP_MS    (BEEP_MS),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .beat    (beat),
        .accent  (accent),
        .enable  (enable),
        .speaker (speaker),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic exp_speaker();
        int h;
        if (!m_active) return IDLE;
        h = m_acc ? HA : HN;
        return (((m_elapsed / h) % 2) == 0) ? ~IDLE : IDLE;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0;
        end else if (beat && enable) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_acc     = accent;
        end else if (m_active) begin
            if (!enable || m_elapsed == BC - 1) m_active = 1'b0;
            else m_elapsed++;
        end
    endtask

    // Apply inputs for one cycle, update the model on the edge, land 1 time unit later.
    task automatic tick(input logic b, input logic a, input logic en);
        beat   = b;
        accent = a;
        enable = en;
        @(posedge sys_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (speaker !== IDLE) begin
            n_errors++;
            $display("FAIL reset_speaker: got %b expected %b", speaker, IDLE);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_normal();
        int busy_cnt = 0;
        int mism = 0;
        tick(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (speaker !== ~IDLE || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL normal_first: got spk=%b busy=%b expected spk=%b busy=1", speaker, busy, ~IDLE);
        end
        for (int i = 0; i < BC + 5; i++) begin
            if (busy) busy_cnt++;
            if (speaker !== exp_speaker() || busy !== m_active) mism++;
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end
        n_checks++;
        if (mism != 0) begin
            n_errors++;
            $display("FAIL normal_wave: %0d cycles differ from model, expected 0", mism);
        end
        n_checks++;
        if (busy_cnt != BC) begin
            n_errors++;
            $display("FAIL normal_busy_len: got %0d expected %0d", busy_cnt, BC);
        end
    endtask

    task automatic test_accent();
        int busy_cnt = 0;
        int toggles  = 0;
        logic prev;
        tick(1'b1, 1'b1, 1'b1);
        prev = speaker;
        for (int i = 0; i < BC + 3; i++) begin
            if (busy) busy_cnt++;
            n_checks++;
            if (speaker !== exp_speaker()) begin
                n_errors++;
                $display("FAIL accent_wave[%0d]: got %b expected %b", i, speaker, exp_speaker());
            end
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            if (busy && speaker !== prev) toggles++;
            prev = speaker;
        end
        n_checks++;
        if (toggles != BC / HA - 1 || busy_cnt != BC) begin
            n_errors++;
            $display("FAIL accent_shape: got toggles=%0d busy=%0d expected toggles=%0d busy=%0d",
                     toggles, busy_cnt, BC / HA - 1, BC);
        end
    endtask

    task automatic test_retrigger();
        int busy_cnt = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 12; i++) begin
            if (busy) busy_cnt++;
            tick(1'b0, 1'b0, 1'b1);
        end
        if (busy) busy_cnt++;
        tick(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (speaker !== ~IDLE || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL retrig_edge: got spk=%b busy=%b expected spk=%b busy=1", speaker, busy, ~IDLE);
        end
        for (int i = 0; i < BC + 3; i++) begin
            if (busy) busy_cnt++;
            n_checks++;
            if (speaker !== exp_speaker() || busy !== m_active) begin
                n_errors++;
                $display("FAIL retrig_wave[%0d]: got spk=%b busy=%b expected spk=%b busy=%b",
                         i, speaker, busy, exp_speaker(), m_active);
            end
            tick(1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (busy_cnt != 12 + BC) begin
            n_errors++;
            $display("FAIL retrig_busy_len: got %0d expected %0d", busy_cnt, 12 + BC);
        end
    endtask

    task automatic test_mute();
        int activity = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 7; i++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (speaker !== IDLE || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mute_abort: got spk=%b busy=%b expected spk=%b busy=0", speaker, busy, IDLE);
        end
        for (int i = 0; i < 6; i++) begin
            tick(i[0] ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            if (busy !== 1'b0 || speaker !== IDLE) activity++;
        end
        n_checks++;
        if (activity != 0) begin
            n_errors++;
            $display("FAIL mute_beat_ignored: %0d active cycles, expected 0", activity);
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int mism = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 9; i++) tick(1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (speaker !== IDLE || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: got spk=%b busy=%b expected spk=%b busy=0", speaker, busy, IDLE);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < BC + 2; i++) begin
            if (speaker !== exp_speaker() || busy !== m_active) mism++;
            tick(1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (mism != 0) begin
            n_errors++;
            $display("FAIL reset_recover: %0d cycles differ from model, expected 0", mism);
        end
    endtask

    task automatic test_boundary();
        int idle_seen = 0;
        int busy_cnt  = 0;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < BC; i++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        if (busy !== 1'b1) idle_seen++;
        for (int i = 0; i < BC + 3; i++) begin
            if (busy) busy_cnt++;
            n_checks++;
            if (speaker !== exp_speaker() || busy !== m_active) begin
                n_errors++;
                $display("FAIL boundary_wave[%0d]: got spk=%b busy=%b expected spk=%b busy=%b",
                         i, speaker, busy, exp_speaker(), m_active);
            end
            tick(1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (idle_seen != 0 || busy_cnt != BC) begin
            n_errors++;
            $display("FAIL boundary_burst: got gap=%0d busy=%0d expected gap=0 busy=%0d",
                     idle_seen, busy_cnt, BC);
        end
    endtask

    task automatic test_random();
        logic b, en;
        for (int i = 0; i < 400; i++) begin
            b  = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 24) != 0);
            tick(b, 1'($urandom_range(0, 1)), en);
            n_checks++;
            if (speaker !== exp_speaker() || busy !== m_active) begin
                n_errors++;
                $display("FAIL random[%0d]: got spk=%b busy=%b expected spk=%b busy=%b",
                         i, speaker, busy, exp_speaker(), m_active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_accent();
        test_retrigger();
        test_mute();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
